// File: rtl/pe_types.sv
// ============================================================================
//  Module      : pe_types
//  Description : Shared state encoding, command-beat flags and helpers for the
//                PE command sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pe_types;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_DONE    = 3'd4
  } pe_seq_state_e;

  typedef struct packed {
    logic ivalid;
    logic ram_we;
    logic feature_valid;
    logic flush_acc;
    logic send_output;
  } pe_cmd_beat_t;

  localparam pe_cmd_beat_t CMD_IDLE = '0;

  // Id fields keep at least one bit even for a single PE or filter.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pe_seq_addr_gen.sv
// ============================================================================
//  Module      : pe_seq_addr_gen
//  Description : Nested RAM-write address walker: addr fastest, then filter id,
//                then PE id.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pe_seq_addr_gen
  import pe_types::*;
#(
  parameter int NUM_PES     = 8,
  parameter int NUM_FILTERS = 4,
  parameter int ADDR_W      = 9,
  localparam int PE_ID_W    = id_width(NUM_PES),
  localparam int FLT_ID_W   = id_width(NUM_FILTERS),
  localparam int NW         = ADDR_W + 1
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                i_clear,
  input  logic                i_advance,
  input  logic [NW-1:0]       i_num_words,
  output logic [ADDR_W-1:0]   o_addr,
  output logic [FLT_ID_W-1:0] o_filter_id,
  output logic [PE_ID_W-1:0]  o_pe_id,
  output logic                o_last
);

  logic [ADDR_W-1:0]   r_addr;
  logic [FLT_ID_W-1:0] r_filter_id;
  logic [PE_ID_W-1:0]  r_pe_id;

  logic w_addr_last;
  logic w_flt_last;
  logic w_pe_last;

  assign w_addr_last = ({1'b0, r_addr} == (i_num_words - NW'(1)));
  assign w_flt_last  = (r_filter_id == FLT_ID_W'(NUM_FILTERS - 1));
  assign w_pe_last   = (r_pe_id == PE_ID_W'(NUM_PES - 1));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_addr      <= '0;
      r_filter_id <= '0;
      r_pe_id     <= '0;
    end else if (i_clear) begin
      r_addr      <= '0;
      r_filter_id <= '0;
      r_pe_id     <= '0;
    end else if (i_advance) begin
      if (w_addr_last) begin
        r_addr <= '0;
        if (w_flt_last) begin
          r_filter_id <= '0;
          r_pe_id     <= w_pe_last ? '0 : r_pe_id + PE_ID_W'(1);
        end else begin
          r_filter_id <= r_filter_id + FLT_ID_W'(1);
        end
      end else begin
        r_addr <= r_addr + ADDR_W'(1);
      end
    end
  end

  assign o_addr      = r_addr;
  assign o_filter_id = r_filter_id;
  assign o_pe_id     = r_pe_id;
  assign o_last      = w_addr_last && w_flt_last && w_pe_last;

endmodule

`default_nettype wire

// File: rtl/pe_cmd_sequencer.sv
// ============================================================================
//  Module      : pe_cmd_sequencer
//  Description : Job-driven sequencer that loads filter RAMs across a PE chain
//                and then streams feature beats with flush/send markers.
//                Optional stall counter enabled by PE_SEQ_PERF_CNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pe_cmd_sequencer
  import pe_types::*;
#(
  parameter int NUM_PES        = 8,
  parameter int NUM_FILTERS    = 4,
  parameter int RAM_DEPTH      = 512,
  parameter int WORD_WIDTH     = 64,
  parameter int LEN_WIDTH      = 16,
  parameter int DRAIN_CYCLES   = 16,
  localparam int RAM_ADDR_WIDTH = $clog2(RAM_DEPTH),
  localparam int PE_ID_W        = id_width(NUM_PES),
  localparam int FLT_ID_W       = id_width(NUM_FILTERS),
  localparam int DRAIN_W        = id_width(DRAIN_CYCLES + 1)
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic                      job_valid,
  output logic                      job_ready,
  input  logic [RAM_ADDR_WIDTH:0]   job_num_filter_words,
  input  logic [LEN_WIDTH-1:0]      job_num_features,
  input  logic [LEN_WIDTH-1:0]      job_num_passes,
  input  logic                      flt_valid,
  output logic                      flt_ready,
  input  logic [WORD_WIDTH-1:0]     flt_data,
  input  logic                      ftr_valid,
  output logic                      ftr_ready,
  input  logic [WORD_WIDTH-1:0]     ftr_data,
  input  logic                      pe_oready,
  output logic                      pe_ivalid,
  output logic                      pe_ram_we,
  output logic [PE_ID_W-1:0]        pe_pe_id,
  output logic [FLT_ID_W-1:0]       pe_filter_id,
  output logic [RAM_ADDR_WIDTH-1:0] pe_addr,
  output logic [WORD_WIDTH-1:0]     pe_wdata,
  output logic                      pe_feature_valid,
  output logic [WORD_WIDTH-1:0]     pe_feature_data,
  output logic [RAM_ADDR_WIDTH-1:0] pe_filter_read_addr,
  output logic                      pe_flush_accumulator,
  output logic                      pe_send_output,
  output logic                      busy,
  output logic                      done
`ifdef PE_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]               perf_stall_cycles
`endif
);

  pe_seq_state_e             r_state;
  pe_cmd_beat_t              r_cmd;
  logic                      r_job_ready;
  logic                      r_busy;
  logic                      r_done;
  logic [RAM_ADDR_WIDTH:0]   r_num_words;
  logic [LEN_WIDTH-1:0]      r_num_features;
  logic [LEN_WIDTH-1:0]      r_num_passes;
  logic [LEN_WIDTH-1:0]      r_beat;
  logic [LEN_WIDTH-1:0]      r_pass;
  logic [DRAIN_W-1:0]        r_drain;
  logic [PE_ID_W-1:0]        r_pe_id;
  logic [FLT_ID_W-1:0]       r_filter_id;
  logic [RAM_ADDR_WIDTH-1:0] r_addr;
  logic [WORD_WIDTH-1:0]     r_wdata;
  logic [WORD_WIDTH-1:0]     r_feature_data;
  logic [RAM_ADDR_WIDTH-1:0] r_read_addr;

  logic                      w_job_fire;
  logic                      w_flt_fire;
  logic                      w_ftr_fire;
  logic                      w_job_has_compute;
  logic                      w_last_beat;
  logic                      w_last_pass;
  logic [RAM_ADDR_WIDTH-1:0] w_gen_addr;
  logic [FLT_ID_W-1:0]       w_gen_filter_id;
  logic [PE_ID_W-1:0]        w_gen_pe_id;
  logic                      w_gen_last;

  assign flt_ready         = (r_state == ST_LOAD) && pe_oready;
  assign ftr_ready         = (r_state == ST_COMPUTE) && pe_oready;
  assign w_job_fire        = (r_state == ST_IDLE) && r_job_ready && job_valid;
  assign w_flt_fire        = flt_valid && flt_ready;
  assign w_ftr_fire        = ftr_valid && ftr_ready;
  assign w_job_has_compute = (job_num_features != '0) && (job_num_passes != '0);
  assign w_last_beat       = (r_beat == (r_num_features - LEN_WIDTH'(1)));
  assign w_last_pass       = (r_pass == (r_num_passes - LEN_WIDTH'(1)));

  pe_seq_addr_gen #(
    .NUM_PES     (NUM_PES),
    .NUM_FILTERS (NUM_FILTERS),
    .ADDR_W      (RAM_ADDR_WIDTH)
  ) u_addr_gen (
    .clock       (clock),
    .resetn      (resetn),
    .i_clear     (w_job_fire),
    .i_advance   (w_flt_fire),
    .i_num_words (r_num_words),
    .o_addr      (w_gen_addr),
    .o_filter_id (w_gen_filter_id),
    .o_pe_id     (w_gen_pe_id),
    .o_last      (w_gen_last)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state        <= ST_IDLE;
      r_cmd          <= CMD_IDLE;
      r_job_ready    <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_num_words    <= '0;
      r_num_features <= '0;
      r_num_passes   <= '0;
      r_beat         <= '0;
      r_pass         <= '0;
      r_drain        <= '0;
      r_pe_id        <= '0;
      r_filter_id    <= '0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_feature_data <= '0;
      r_read_addr    <= '0;
    end else begin
      r_cmd  <= CMD_IDLE;
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_job_fire) begin
            r_num_words    <= job_num_filter_words;
            r_num_features <= job_num_features;
            r_num_passes   <= job_num_passes;
            r_beat         <= '0;
            r_pass         <= '0;
            r_busy         <= 1'b1;
            r_job_ready    <= 1'b0;
            if (job_num_filter_words != '0) begin
              r_state <= ST_LOAD;
            end else if (w_job_has_compute) begin
              r_state <= ST_COMPUTE;
            end else begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end else begin
            r_job_ready <= 1'b1;
          end
        end

        ST_LOAD: begin
          if (w_flt_fire) begin
            r_cmd.ivalid <= 1'b1;
            r_cmd.ram_we <= 1'b1;
            r_pe_id      <= w_gen_pe_id;
            r_filter_id  <= w_gen_filter_id;
            r_addr       <= w_gen_addr;
            r_wdata      <= flt_data;
            if (w_gen_last) begin
              if ((r_num_features != '0) && (r_num_passes != '0)) begin
                r_state <= ST_COMPUTE;
              end else begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
              end
            end
          end
        end

        ST_COMPUTE: begin
          if (w_ftr_fire) begin
            r_cmd.ivalid        <= 1'b1;
            r_cmd.feature_valid <= 1'b1;
            r_cmd.flush_acc     <= (r_beat == '0);
            r_cmd.send_output   <= w_last_beat;
            r_feature_data      <= ftr_data;
            r_read_addr         <= RAM_ADDR_WIDTH'(r_beat);
            if (w_last_beat) begin
              r_beat <= '0;
              if (w_last_pass) begin
                r_state <= ST_DRAIN;
                r_drain <= DRAIN_W'(DRAIN_CYCLES);
              end else begin
                r_pass <= r_pass + LEN_WIDTH'(1);
              end
            end else begin
              r_beat <= r_beat + LEN_WIDTH'(1);
            end
          end
        end

        // First DRAIN cycle carries the final send_output beat, so the
        // countdown yields DRAIN_CYCLES idle cycles after it.
        ST_DRAIN: begin
          if (r_drain == '0) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else begin
            r_drain <= r_drain - DRAIN_W'(1);
          end
        end

        ST_DONE: begin
          r_state     <= ST_IDLE;
          r_busy      <= 1'b0;
          r_job_ready <= 1'b1;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign job_ready            = r_job_ready;
  assign busy                 = r_busy;
  assign done                 = r_done;
  assign pe_ivalid            = r_cmd.ivalid;
  assign pe_ram_we            = r_cmd.ram_we;
  assign pe_feature_valid     = r_cmd.feature_valid;
  assign pe_flush_accumulator = r_cmd.flush_acc;
  assign pe_send_output       = r_cmd.send_output;
  assign pe_pe_id             = r_pe_id;
  assign pe_filter_id         = r_filter_id;
  assign pe_addr              = r_addr;
  assign pe_wdata             = r_wdata;
  assign pe_feature_data      = r_feature_data;
  assign pe_filter_read_addr  = r_read_addr;

`ifdef PE_SEQ_PERF_CNT_EN
  logic [31:0] r_perf_stall;
  logic        w_stall;

  assign w_stall = ((r_state == ST_LOAD) && !w_flt_fire) ||
                   ((r_state == ST_COMPUTE) && !w_ftr_fire);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_perf_stall <= '0;
    end else if (w_job_fire) begin
      r_perf_stall <= '0;
    end else if (w_stall && (r_perf_stall != '1)) begin
      r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_stall_cycles = r_perf_stall;
`endif

endmodule

`default_nettype wire
